cdc_loopback_mc: RTL and testbench
==================================

Name: cdc_loopback_mc

Overview:
- Parametrised multi-channel application core that replaces the single-channel byte loopback behind usb_cdc's OUT/IN byte streams.
- Each channel buffers OUT bytes in a private FIFO, optionally transforms them, and returns them on the IN stream.
- New relative to the plain loopback: configurable channel count and depth, per-channel transform modes, and a hold/flush mode that batches bytes until the FIFO is full or the stream has been idle for a set time.
- Sits in the application clock domain next to usb_cdc.

Parameters:
CHANNELS, 1, number of independent loopback channels (1..4)
DEPTH, 16, bytes per channel FIFO; power of 2, 2..256
IDLE_CYCLES, 1000, idle cycles before hold mode flushes; >=1
Derived: AW = log2(DEPTH)

Ports:
clk_i  in  1  application clock
rst_i  in  1  reset; synchronous, active-high
out_data_i  in  8*CHANNELS  OUT bytes from usb_cdc; channel c at [8c+7:8c]
out_valid_i  in  CHANNELS  OUT byte valid, per channel
out_ready_o  out  CHANNELS  OUT byte accepted when valid&ready
in_data_o  out  8*CHANNELS  IN bytes to usb_cdc
in_valid_o  out  CHANNELS  IN byte valid
in_ready_i  in  CHANNELS  IN byte consumed when valid&ready
mode_i  in  2*CHANNELS  per channel: 0 echo, 1 invert, 2 increment, 3 hold/flush
level_o  out  (AW+1)*CHANNELS  per-channel FIFO occupancy, 0..DEPTH

Behaviour:
- One clock, clk_i. rst_i is synchronous, active-high.
- Channels are fully independent. All channel state below is per channel.
- Reset: pointers, count and idle counter cleared; state = PASS.
- Reset values: out_ready_o = 0 while rst_i = 1, then 1 from the first cycle after release. in_valid_o = 0, in_data_o = 0, level_o = 0.
- Write: a byte is accepted on a cycle with out_valid_i & out_ready_o.
- out_ready_o = ~rst_i & (count != DEPTH). It is based on registered count, so no write is accepted on a full FIFO even if a read happens in the same cycle.
- Transform is applied at write time:
  - mode 0: byte unchanged.
  - mode 1: ~byte.
  - mode 2: byte + 1, modulo 256 (0xFF -> 0x00).
  - mode 3: byte unchanged.
  - A mode change affects only bytes accepted after the change; bytes already buffered are not altered.
- Read side: first-word-fall-through, registered output.
  - A byte accepted in cycle N is visible on in_data_o with in_valid_o = 1 in cycle N+1 (PASS state, FIFO previously empty).
  - in_data_o holds stable while in_valid_o & ~in_ready_i.
  - Reads at full rate are sustained: 1 byte/cycle.
- Simultaneous read and write: count unchanged. level_o updates one cycle after the accept/consume edge.
- Wrap-around: pointers are AW bits and wrap naturally. count is AW+1 bits.
- in_valid_o = 0 when the FIFO is empty. In that case in_data_o keeps its last value (don't-care).
- State machine, per channel:
  - PASS: in_valid_o = ~empty. If mode_i = 3 -> HOLD.
  - HOLD: in_valid_o forced 0.
    - Idle counter resets to 0 on every accepted write, and also while empty. Otherwise it increments, saturating at IDLE_CYCLES.
    - -> DRAIN when (idle counter == IDLE_CYCLES & ~empty) or count == DEPTH.
    - If mode_i != 3 -> PASS; this has priority.
  - DRAIN: in_valid_o = ~empty. Writes are still accepted.
    - -> HOLD when the FIFO goes empty (count becomes 0 after a consume) and mode_i = 3.
    - -> PASS when mode_i != 3.
- Mode exit: switching from 3 to 0/1/2 while in HOLD releases the buffered bytes untransformed, starting the next cycle.
- Reset mid-operation: buffered data is discarded. in_valid_o drops in the reset cycle. No partial byte is emitted.
- X-safety: out_data_i is ignored when out_valid_i = 0.

Test Plan:
- Reset/idle: hold rst_i 3 cycles with out_valid_i = 1 -> out_ready_o = 0 and in_valid_o = 0 throughout; out_ready_o = 1 the cycle after release; level_o = 0.
- Echo, CHANNELS=2, ch0 mode 0: write 0x01..0x07 back-to-back with in_ready_i = 1 -> in_data_o = 0x01..0x07, each 1 cycle after its accept; ch1 untouched, level = 0.
- Transforms: ch0 mode 1 write 0x5A -> 0xA5. Mode 2 write 0xFF, 0x10 -> 0x00, 0x11. Switch mode 2 -> 0 with 0x10 still buffered -> it reads as 0x11.
- Full/backpressure, DEPTH=16: in_ready_i = 0, write 20 bytes -> 16 accepted, out_ready_o = 0, level_o = 16. Raise in_ready_i for 1 cycle with valid pending -> level_o = 16 - 1; then next write is accepted; order preserved.
- Hold by timeout, IDLE_CYCLES=10: mode 3, write 0x41,0x42,0x43 then stop -> in_valid_o = 0 for 10 idle cycles, then 3 bytes drained in order and state back to HOLD; a write at idle count 9 restarts the count.
- Hold by full and mid-drain reset: mode 3, DEPTH=16, write 16 bytes -> drain starts without waiting for timeout. Assert rst_i after 5 bytes read -> in_valid_o = 0, level_o = 0, and no further data after release.

Source files
------------

// File: rtl/cdc_loopback_mc_if.sv
// Byte-stream bundle between usb_cdc and the multi-channel loopback core.
// Each channel owns an 8-bit OUT lane, an 8-bit IN lane, a 2-bit mode and an AW+1 bit level.
interface cdc_loopback_mc_if #(
  parameter int CHANNELS = 1,
  parameter int AW       = 4
);
  logic [8*CHANNELS-1:0]      out_data_i;
  logic [CHANNELS-1:0]        out_valid_i;
  logic [CHANNELS-1:0]        out_ready_o;
  logic [8*CHANNELS-1:0]      in_data_o;
  logic [CHANNELS-1:0]        in_valid_o;
  logic [CHANNELS-1:0]        in_ready_i;
  logic [2*CHANNELS-1:0]      mode_i;
  logic [(AW+1)*CHANNELS-1:0] level_o;

  modport slave (
    input  out_data_i, out_valid_i, in_ready_i, mode_i,
    output out_ready_o, in_data_o, in_valid_o, level_o
  );

  modport master (
    output out_data_i, out_valid_i, in_ready_i, mode_i,
    input  out_ready_o, in_data_o, in_valid_o, level_o
  );
endinterface

// File: rtl/cdc_loopback_mc.sv
// Multi-channel byte loopback: per-channel FIFO with write-time transform,
// first-word-fall-through registered read head, and a hold/flush batching mode.
module cdc_loopback_mc #(
  parameter int CHANNELS    = 1,
  parameter int DEPTH       = 16,
  parameter int IDLE_CYCLES = 1000
) (
  input logic              clk_i,
  input logic              rst_i,
  cdc_loopback_mc_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = $clog2(IDLE_CYCLES + 1);

  localparam logic [1:0] PASS  = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);

  function automatic logic [7:0] xform(input logic [7:0] b, input logic [1:0] m);
    case (m)
      2'd1:    return ~b;
      2'd2:    return b + 8'd1;
      default: return b;
    endcase
  endfunction

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [AW:0]   count, count_nxt;
    logic [IW-1:0] idle;
    logic [1:0]    state;
    logic [1:0]    mode;
    logic [7:0]    wdata, data_p1, head_nxt;
    logic          empty, full, wr_en, rd_en, vld_p1;

    assign mode   = bus.mode_i[2*c +: 2];
    assign empty  = (count == '0);
    assign full   = (count == FULL_LVL);
    assign wr_en  = bus.out_valid_i[c] & ~rst_i & ~full;
    assign vld_p1 = ~rst_i & ~empty & (state != HOLD);
    assign rd_en  = vld_p1 & bus.in_ready_i[c];
    assign wdata  = xform(bus.out_data_i[8*c +: 8], mode);

    assign rd_ptr_nxt = rd_ptr + AW'(rd_en);
    assign count_nxt  = count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    // Writing into an otherwise-empty FIFO makes the incoming byte the next head.
    assign head_nxt   = (wr_en && (wr_ptr == rd_ptr_nxt)) ? wdata : mem[rd_ptr_nxt];

    always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_ptr] <= wdata;
    end

    // Stage p1: pointers, occupancy and the registered read head
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        data_p1 <= '0;
      end else begin
        wr_ptr <= wr_ptr + AW'(wr_en);
        rd_ptr <= rd_ptr_nxt;
        count  <= count_nxt;
        if (count_nxt != '0) data_p1 <= head_nxt;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state <= PASS;
        idle  <= '0;
      end else begin
        case (state)
          PASS:    if (mode == 2'd3) state <= HOLD;
          HOLD:    if (mode != 2'd3) state <= PASS;
                   else if (((idle == IDLE_MAX) && !empty) || full) state <= DRAIN;
          DRAIN:   if (mode != 2'd3) state <= PASS;
                   else if (rd_en && (count_nxt == '0)) state <= HOLD;
          default: state <= PASS;
        endcase
        // Idle timer only runs while holding a non-empty FIFO with no new traffic.
        if ((state == HOLD) && !wr_en && !empty) begin
          if (idle != IDLE_MAX) idle <= idle + IW'(1);
        end else begin
          idle <= '0;
        end
      end
    end

    assign bus.out_ready_o[c]              = ~rst_i & ~full;
    assign bus.in_valid_o[c]               = vld_p1;
    assign bus.in_data_o[8*c +: 8]         = data_p1;
    assign bus.level_o[(AW+1)*c +: (AW+1)] = count;
  end
endmodule

// File: tb/tb_cdc_loopback_mc.sv
// Scoreboard bench for cdc_loopback_mc: two channels, DEPTH 16, IDLE_CYCLES 10; channel 0 exercised.
module tb_cdc_loopback_mc;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdc_loopback_mc_if #(.CHANNELS(2), .AW(4)) bus ();

  cdc_loopback_mc #(.CHANNELS(2), .DEPTH(16), .IDLE_CYCLES(10)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int         checks = 0;
  int         passed = 0;
  logic [7:0] sb[$];
  logic       acc, rd;
  logic [7:0] rdat, exp_b;

  function automatic logic [7:0] model(input logic [7:0] b, input logic [1:0] m);
    if (m == 2'd1) return ~b;
    if (m == 2'd2) return b + 8'd1;
    return b;
  endfunction

  // One cycle on channel 0: drive at negedge, observe handshakes 1ns later.
  task automatic cyc(input logic [7:0] d, input logic v, input logic r, input logic [1:0] m,
                     output logic a, output logic rr, output logic [7:0] rd_d);
    @(negedge clk);
    bus.out_data_i[7:0] = v ? d : 8'($urandom);
    bus.out_valid_i[0]  = v;
    bus.in_ready_i[0]   = r;
    bus.mode_i[1:0]     = m;
    #1;
    a    = v & bus.out_ready_o[0];
    rr   = bus.in_valid_o[0] & r;
    rd_d = bus.in_data_o[7:0];
    if (a) sb.push_back(model(d, m));
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    bus.out_valid_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.out_ready_o !== 2'b00) $display("FAIL reset_ready: got %b want 00", bus.out_ready_o); else passed++;
      checks++; if (bus.in_valid_o !== 2'b00) $display("FAIL reset_valid: got %b want 00", bus.in_valid_o); else passed++;
      @(negedge clk);
    end
    rst = 1'b0;
    bus.out_valid_i = 2'b00;
    #1;
    checks++; if (bus.out_ready_o !== 2'b11) $display("FAIL release_ready: got %b want 11", bus.out_ready_o); else passed++;
    checks++; if (bus.level_o !== 10'd0) $display("FAIL reset_level: got %h want 0", bus.level_o); else passed++;
    checks++; if (bus.in_data_o !== 16'h0000) $display("FAIL reset_data: got %h want 0000", bus.in_data_o); else passed++;
    checks++; if (bus.in_valid_o !== 2'b00) $display("FAIL release_valid: got %b want 00", bus.in_valid_o); else passed++;
  endtask

  task automatic test_echo;
    logic prev = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cyc(8'(i), i <= 7, 1'b1, 2'd0, acc, rd, rdat);
      checks++; if (rd !== prev) $display("FAIL echo_latency: cycle %0d valid %b want %b", i, rd, prev); else passed++;
      if (rd) begin
        checks++;
        if (sb.size() == 0) $display("FAIL echo_data: unexpected byte %02h want none", rdat);
        else begin exp_b = sb.pop_front(); if (rdat !== exp_b) $display("FAIL echo_data: got %02h want %02h", rdat, exp_b); else passed++; end
      end
      prev = acc;
    end
    checks++; if (bus.in_valid_o[1] !== 1'b0) $display("FAIL echo_ch1_valid: got %b want 0", bus.in_valid_o[1]); else passed++;
    checks++; if (bus.level_o[9:5] !== 5'd0) $display("FAIL echo_ch1_level: got %0d want 0", bus.level_o[9:5]); else passed++;
    checks++; if (sb.size() != 0) $display("FAIL echo_left: got %0d bytes outstanding want 0", sb.size()); else passed++;
  endtask

  task automatic test_transforms;
    cyc(8'h5A, 1'b1, 1'b1, 2'd1, acc, rd, rdat);
    cyc(8'h00, 1'b0, 1'b0, 2'd2, acc, rd, rdat);
    cyc(8'hFF, 1'b1, 1'b0, 2'd2, acc, rd, rdat);
    cyc(8'h10, 1'b1, 1'b0, 2'd2, acc, rd, rdat);
    cyc(8'h00, 1'b0, 1'b0, 2'd0, acc, rd, rdat);
    cyc(8'h33, 1'b1, 1'b0, 2'd0, acc, rd, rdat);
    for (int i = 0; i < 8; i++) begin
      cyc(8'h00, 1'b0, 1'b1, 2'd0, acc, rd, rdat);
      if (rd) begin
        checks++;
        if (sb.size() == 0) $display("FAIL xform_data: unexpected byte %02h want none", rdat);
        else begin exp_b = sb.pop_front(); if (rdat !== exp_b) $display("FAIL xform_data: got %02h want %02h", rdat, exp_b); else passed++; end
      end
    end
    checks++; if (sb.size() != 0) $display("FAIL xform_left: got %0d bytes outstanding want 0", sb.size()); else passed++;
  endtask

  task automatic test_full;
    int n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(8'h80 + 8'(i), 1'b1, 1'b0, 2'd0, acc, rd, rdat);
      if (acc) n_acc++;
    end
    checks++; if (n_acc != 16) $display("FAIL full_accepts: got %0d want 16", n_acc); else passed++;
    checks++; if (bus.out_ready_o[0] !== 1'b0) $display("FAIL full_ready: got %b want 0", bus.out_ready_o[0]); else passed++;
    checks++; if (bus.level_o[4:0] !== 5'd16) $display("FAIL full_level: got %0d want 16", bus.level_o[4:0]); else passed++;
    cyc(8'h99, 1'b1, 1'b1, 2'd0, acc, rd, rdat);
    checks++; if (acc !== 1'b0) $display("FAIL full_rw_accept: got %b want 0", acc); else passed++;
    if (rd) begin
      checks++;
      exp_b = sb.pop_front();
      if (rdat !== exp_b) $display("FAIL full_data: got %02h want %02h", rdat, exp_b); else passed++;
    end
    cyc(8'h99, 1'b1, 1'b0, 2'd0, acc, rd, rdat);
    checks++; if (bus.level_o[4:0] !== 5'd15) $display("FAIL full_level_after_read: got %0d want 15", bus.level_o[4:0]); else passed++;
    checks++; if (acc !== 1'b1) $display("FAIL full_next_accept: got %b want 1", acc); else passed++;
    cyc(8'h00, 1'b0, 1'b0, 2'd0, acc, rd, rdat);
    checks++; if (bus.level_o[4:0] !== 5'd16) $display("FAIL full_refill_level: got %0d want 16", bus.level_o[4:0]); else passed++;
    for (int i = 0; i < 20; i++) begin
      cyc(8'h00, 1'b0, 1'b1, 2'd0, acc, rd, rdat);
      if (rd) begin
        checks++;
        if (sb.size() == 0) $display("FAIL full_order: unexpected byte %02h want none", rdat);
        else begin exp_b = sb.pop_front(); if (rdat !== exp_b) $display("FAIL full_order: got %02h want %02h", rdat, exp_b); else passed++; end
      end
    end
    checks++; if (sb.size() != 0) $display("FAIL full_left: got %0d bytes outstanding want 0", sb.size()); else passed++;
    checks++; if (bus.level_o[4:0] !== 5'd0) $display("FAIL full_drained_level: got %0d want 0", bus.level_o[4:0]); else passed++;
  endtask

  task automatic test_hold_timeout;
    int n_rd = 0;
    int n_early = 0;
    cyc(8'h00, 1'b0, 1'b1, 2'd3, acc, rd, rdat);
    for (int i = 0; i < 3; i++) begin
      cyc(8'h41 + 8'(i), 1'b1, 1'b1, 2'd3, acc, rd, rdat);
      if (rd) n_early++;
    end
    for (int i = 0; i < 9; i++) begin
      cyc(8'h00, 1'b0, 1'b1, 2'd3, acc, rd, rdat);
      if (rd) n_early++;
    end
    cyc(8'h44, 1'b1, 1'b1, 2'd3, acc, rd, rdat);
    if (rd) n_early++;
    checks++; if (n_early != 0) $display("FAIL hold_before_restart: got %0d reads want 0", n_early); else passed++;
    for (int i = 0; i < 10; i++) begin
      cyc(8'h00, 1'b0, 1'b1, 2'd3, acc, rd, rdat);
      checks++; if (rd !== 1'b0) $display("FAIL hold_idle_valid: idle cycle %0d got %b want 0", i, rd); else passed++;
    end
    for (int i = 0; i < 30 && n_rd < 4; i++) begin
      cyc(8'h00, 1'b0, 1'b1, 2'd3, acc, rd, rdat);
      if (rd) begin
        n_rd++;
        checks++;
        exp_b = sb.pop_front();
        if (rdat !== exp_b) $display("FAIL hold_drain_data: got %02h want %02h", rdat, exp_b); else passed++;
      end
    end
    checks++; if (n_rd != 4) $display("FAIL hold_drain_count: got %0d want 4", n_rd); else passed++;
    cyc(8'h45, 1'b1, 1'b1, 2'd3, acc, rd, rdat);
    cyc(8'h00, 1'b0, 1'b1, 2'd3, acc, rd, rdat);
    checks++; if (rd !== 1'b0) $display("FAIL hold_rearm: got valid %b want 0", rd); else passed++;
    cyc(8'h00, 1'b0, 1'b1, 2'd0, acc, rd, rdat);
    cyc(8'h00, 1'b0, 1'b1, 2'd0, acc, rd, rdat);
    checks++; if (rd !== 1'b1) $display("FAIL hold_exit_valid: got %b want 1", rd); else passed++;
    if (rd) begin
      checks++;
      exp_b = sb.pop_front();
      if (rdat !== exp_b) $display("FAIL hold_exit_data: got %02h want %02h", rdat, exp_b); else passed++;
    end
    cyc(8'h00, 1'b0, 1'b1, 2'd0, acc, rd, rdat);
    checks++; if (sb.size() != 0) $display("FAIL hold_left: got %0d bytes outstanding want 0", sb.size()); else passed++;
  endtask

  task automatic test_full_hold_reset;
    int n_acc = 0;
    int wait_c = 0;
    int n_rd = 0;
    logic any_rd = 1'b0;
    cyc(8'h00, 1'b0, 1'b1, 2'd3, acc, rd, rdat);
    cyc(8'h00, 1'b0, 1'b1, 2'd3, acc, rd, rdat);
    for (int i = 0; i < 16; i++) begin
      cyc(8'hC0 + 8'(i), 1'b1, 1'b1, 2'd3, acc, rd, rdat);
      if (acc) n_acc++;
      if (rd) any_rd = 1'b1;
    end
    checks++; if (n_acc != 16) $display("FAIL fhold_accepts: got %0d want 16", n_acc); else passed++;
    checks++; if (any_rd !== 1'b0) $display("FAIL fhold_early_read: got %b want 0", any_rd); else passed++;
    while (n_rd < 5 && wait_c < 20) begin
      cyc(8'h00, 1'b0, 1'b1, 2'd3, acc, rd, rdat);
      wait_c++;
      if (rd) begin
        n_rd++;
        checks++;
        exp_b = sb.pop_front();
        if (rdat !== exp_b) $display("FAIL fhold_data: got %02h want %02h", rdat, exp_b); else passed++;
      end
    end
    checks++; if (wait_c > 7) $display("FAIL fhold_latency: got %0d cycles want <= 7", wait_c); else passed++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.in_valid_o[0] !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", bus.in_valid_o[0]); else passed++;
    @(negedge clk);
    #1;
    checks++; if (bus.level_o[4:0] !== 5'd0) $display("FAIL rst_mid_level: got %0d want 0", bus.level_o[4:0]); else passed++;
    rst = 1'b0;
    sb.delete();
    any_rd = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cyc(8'h00, 1'b0, 1'b1, 2'd0, acc, rd, rdat);
      if (rd) any_rd = 1'b1;
    end
    checks++; if (any_rd !== 1'b0) $display("FAIL rst_mid_residue: got %b want 0", any_rd); else passed++;
  endtask

  initial begin
    rst             = 1'b1;
    bus.out_data_i  = '0;
    bus.out_valid_i = '0;
    bus.in_ready_i  = 2'b11;
    bus.mode_i      = '0;
    test_reset();
    test_echo();
    test_transforms();
    test_full();
    test_hold_timeout();
    test_full_hold_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
